// File: rtl/aes_cipher_seq.sv
// Iterative AES encryption core: one round per clock over an externally expanded key schedule.
// The package carries the byte-level primitives shared with the key-expansion stage.

package aes_cipher_seq_pkg;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    logic [7:0] m;
    p = 8'h00;
    x = a;
    m = b;
    for (int i = 0; i < 8; i++) begin
      if (m[0]) p = p ^ x;
      x = xtime(x);
      m = m >> 1;
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254 (0 maps to 0), followed by the affine transform.
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = a;
    inv = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) o[32*c +: 32] = sub_word(s[32*c +: 32]);
    return o;
  endfunction

  // Row r of column c takes the byte from column (c + r) mod 4.
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[8*(4*c+r) +: 8] = s[8*(4*((c+r)%4)+r) +: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [31:0] mix_column(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    logic [7:0] b0, b1, b2, b3;
    a0 = col[7:0];
    a1 = col[15:8];
    a2 = col[23:16];
    a3 = col[31:24];
    b0 = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
    b1 = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
    b2 = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
    b3 = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    return {b3, b2, b1, b0};
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) o[32*c +: 32] = mix_column(s[32*c +: 32]);
    return o;
  endfunction

endpackage

module aes_cipher_seq #(
  parameter int unsigned Nk = 4,
  parameter int unsigned Nr = Nk + 6
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [4*(Nr+1)-1:0][31:0] rkey,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [127:0]              pt,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [127:0]              ct
);
  import aes_cipher_seq_pkg::*;

  localparam int unsigned RW = $clog2(Nr + 1);
  localparam int unsigned NW = 4 * (Nr + 1);
  localparam int unsigned KW = $clog2(NW);

  typedef enum logic [1:0] {IDLE, ROUND, DONE} fsm_e;

  fsm_e           fsm;
  logic [RW-1:0]  round;
  logic [127:0]   state;

  logic           last_round;
  logic [KW-1:0]  kidx;
  logic [127:0]   round_key;
  logic [127:0]   shifted;
  logic [127:0]   round_out;

  // Full round datapath between the state register and itself.
  always_comb begin
    last_round = (round == RW'(Nr));
    kidx       = KW'({round, 2'b00});
    round_key  = {rkey[kidx + KW'(3)], rkey[kidx + KW'(2)], rkey[kidx + KW'(1)], rkey[kidx]};
    shifted    = shift_rows(sub_bytes(state));
    round_out  = (last_round ? shifted : mix_columns(shifted)) ^ round_key;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fsm       <= IDLE;
      round     <= '0;
      state     <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      ct        <= '0;
    end else begin
      case (fsm)
        IDLE: begin
          if (in_valid && in_ready) begin
            state    <= pt ^ {rkey[3], rkey[2], rkey[1], rkey[0]};
            round    <= RW'(1);
            in_ready <= 1'b0;
            fsm      <= ROUND;
          end
        end
        ROUND: begin
          state <= round_out;
          if (last_round) begin
            ct        <= round_out;
            out_valid <= 1'b1;
            fsm       <= DONE;
          end else begin
            round <= round + RW'(1);
          end
        end
        DONE: begin
          // Ciphertext held until the consumer takes it.
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            fsm       <= IDLE;
          end
        end
        default: begin
          fsm       <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/aes_cipher_seq.md
# aes_cipher_seq

Iterative AES encryption core that consumes the expanded round-key array produced by the key-expansion stage and encrypts one 128-bit block at a time, one round per clock. It sits directly downstream of key expansion: the key-expansion registers drive `rkey`, and this block owns the plaintext/ciphertext valid/ready handshakes toward the datapath.

## Interface
- `Nk`, default 4: key length in 32-bit words (4, 6 or 8).
- `Nr`, default `Nk+6`: number of rounds.

- `clk`  in  1  clock; all state changes on the rising edge.
- `rst_n`  in  1  reset, synchronous and active-low.
- `rkey`  in  32 x 4*(Nr+1)  round-key words; `rkey[4r+c]` is column c of round key r.
- `in_valid`  in  1  plaintext offered.
- `in_ready`  out  1  core idle, plaintext accepted when `in_valid & in_ready`.
- `pt`  in  128  plaintext block.
- `out_valid`  out  1  ciphertext available.
- `out_ready`  in  1  consumer takes ciphertext when `out_valid & out_ready`.
- `ct`  out  128  ciphertext block.

## Operation
- Byte order matches the key-expansion packing:
  - Block byte k is `pt[8k+:8]`.
  - State column c is bits `[32c+:32]`, with byte 0 of the column in bits `[7:0]`.
- FSM has three states.
  - **IDLE**: `in_ready`=1. On accept, `state <= pt ^ {rkey[3],rkey[2],rkey[1],rkey[0]}`, `round <= 1`, go to ROUND.
  - **ROUND**: each cycle `state <= AddRoundKey(MixColumns(ShiftRows(SubBytes(state))), rkey[4*round+:4])`.
    - MixColumns is omitted when `round == Nr`.
    - If `round < Nr`: `round <= round+1`.
    - If `round == Nr`: go to DONE.
  - **DONE**: `out_valid`=1, `ct` = final state, held stable until `out_ready`. On handshake, go to IDLE.
- `round` counter width is `$clog2(Nr+1)`. It never wraps, because it is reloaded on every accept.
- `in_ready`=0 in ROUND and DONE. `in_valid` asserted there is ignored and not queued.
- `rkey` must be held stable from accept until the DONE handshake. The system sequencer must not pulse key-expansion `load` while `in_ready`=0; the core does not detect violations.
- `pt` is sampled only on the accept edge and may change afterwards.
- S-box, ShiftRows and xtime come from the package functions shared with key expansion. One round per cycle is purely combinational between registers.

## Timing
- Reset: on any edge with `rst_n`=0, the block goes to IDLE, `round`=0, state register=0.
  - After reset: `in_ready`=1, `out_valid`=0, `ct`=0.
  - Reset mid-ROUND or in DONE discards the block with no output.
- Latency: accept at edge E gives `out_valid`=1 after edge E+Nr (10/12/14 cycles for Nk=4/6/8).
- Consumer ready: with `out_ready` held 1, `out_valid` is high for exactly one cycle. IDLE is re-entered at edge E+Nr+1, and the next accept is possible at edge E+Nr+2.
  - Maximum throughput: one block per Nr+2 cycles.
- Backpressure: `out_valid`, `ct` and `in_ready`=0 hold indefinitely while `out_ready`=0.
- `in_valid` may rise in the same cycle the DONE handshake completes. It is not accepted until the following cycle, when `in_ready`=1.
- `ct` retains the last ciphertext after returning to IDLE. It is valid only while `out_valid`=1.

## Test plan
- **AES-128 FIPS-197 vector** (Nk=4).
  - Stimulus: `rkey` from key `128'h0f0e0d0c0b0a09080706050403020100`; `pt=128'hffeeddccbbaa99887766554433221100`.
  - Required: `ct=128'h5ac5b47080b7cdd830047b6ad8e0c469`, with `out_valid` rising exactly 10 cycles after accept.
- **AES-256 FIPS-197 vector** (Nk=8).
  - Stimulus: key bytes 00..1f packed byte 0 in `[7:0]`; same `pt`.
  - Required: `ct=128'h8960494b9049fceabf456751cab7a28e` after exactly 14 cycles.
- **Backpressure and busy input.**
  - Stimulus: `out_ready`=0 for 20 cycles in DONE; `in_valid`=1 with a different `pt` throughout ROUND/DONE.
  - Required: `ct` and `out_valid` stable; `in_ready`=0; no second block starts until one cycle after the handshake.
- **Back-to-back** (Nk=4).
  - Stimulus: three blocks with `in_valid` and `out_ready` held 1.
  - Required: accepts spaced exactly 12 cycles apart; each `ct` matches the reference model.
- **Reset mid-operation.**
  - Stimulus: `rst_n`=0 for one edge at round 5.
  - Required: next cycle `in_ready`=1, `out_valid`=0, `ct`=0. A subsequent block encrypts correctly.
- **Reset in DONE.**
  - Stimulus: `rst_n`=0 while `out_valid`=1 and `out_ready`=0.
  - Required: `out_valid` drops on that edge; no handshake occurs.
